// File: rtl/simple_fixed2_pipe.sv
// Halfword/word shift and rotate execute pipe (RR and RI7 forms) on 128-bit big-endian operands.
// Latency: LATENCY cycles from issue edge to registered result; compute in stage 1, the rest pure delay.
// Backpressure: stall freezes every stage and ignores issue; flush clears every valid; optional SF2_HAZARD_QUERY_EN.
module simple_fixed2_pipe #(
  parameter int LATENCY = 3,
  parameter int OPW     = 11
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           stall,
  input  logic           flush,
  input  logic [0:OPW-1] op,
  input  logic [2:0]     format,
  input  logic [6:0]     rt_addr,
  input  logic [0:127]   ra,
  input  logic [0:127]   rb,
  input  logic [0:17]    imm,
  input  logic           reg_write,
`ifdef SF2_HAZARD_QUERY_EN
  input  logic [6:0]     q_addr,
  output logic           q_hit,
  output logic [3:0]     q_stage,
`endif
  output logic [0:127]   rt_wb,
  output logic [6:0]     rt_addr_wb,
  output logic           reg_write_wb
);

  localparam logic [10:0] OP_SHLH  = 11'b00001011111;
  localparam logic [10:0] OP_SHLHI = 11'b00001111111;
  localparam logic [10:0] OP_SHL   = 11'b00001011011;
  localparam logic [10:0] OP_SHLI  = 11'b00001111011;
  localparam logic [10:0] OP_ROTH  = 11'b00001011100;
  localparam logic [10:0] OP_ROTHI = 11'b00001111100;
  localparam logic [10:0] OP_ROT   = 11'b00001011000;
  localparam logic [10:0] OP_ROTI  = 11'b00001111000;

  typedef enum logic [2:0] {K_NONE, K_SHLH, K_SHL, K_ROTH, K_ROT} kind_e;

  kind_e        kind;
  logic         use_imm;
  logic         issue_vld;
  logic [0:127] res;

  logic [0:127] rt_q   [1:LATENCY];
  logic [0:127] rt_d   [1:LATENCY];
  logic [6:0]   addr_q [1:LATENCY];
  logic [6:0]   addr_d [1:LATENCY];
  logic         we_q   [1:LATENCY];
  logic         we_d   [1:LATENCY];

  // Upper immediate bits are outside the RI7 count field.
  logic unused_imm;
  assign unused_imm = ^imm[0:11];

  function automatic logic [15:0] hw_shl(input logic [15:0] a, input logic [4:0] c);
    return c[4] ? 16'h0000 : (a << c[3:0]);
  endfunction

  function automatic logic [15:0] hw_rot(input logic [15:0] a, input logic [3:0] c);
    logic [31:0] t;
    t = {a, a} << c;
    return t[31:16];
  endfunction

  function automatic logic [31:0] wd_shl(input logic [31:0] a, input logic [5:0] c);
    return c[5] ? 32'h0 : (a << c[4:0]);
  endfunction

  function automatic logic [31:0] wd_rot(input logic [31:0] a, input logic [4:0] c);
    logic [63:0] t;
    t = {a, a} << c;
    return t[63:32];
  endfunction

  // Decode: opcode must agree with the format; anything else is a bubble.
  always_comb begin
    kind    = K_NONE;
    use_imm = 1'b0;
    if (format == 3'd0) begin
      case (op)
        OPW'(OP_SHLH): kind = K_SHLH;
        OPW'(OP_SHL):  kind = K_SHL;
        OPW'(OP_ROTH): kind = K_ROTH;
        OPW'(OP_ROT):  kind = K_ROT;
        default:       kind = K_NONE;
      endcase
    end else if (format == 3'd1) begin
      use_imm = 1'b1;
      case (op)
        OPW'(OP_SHLHI): kind = K_SHLH;
        OPW'(OP_SHLI):  kind = K_SHL;
        OPW'(OP_ROTHI): kind = K_ROTH;
        OPW'(OP_ROTI):  kind = K_ROT;
        default:        kind = K_NONE;
      endcase
    end
    if (!reg_write) kind = K_NONE;
    issue_vld = (kind != K_NONE);
  end

  // Element-wise shift/rotate; RR takes each count from the matching rb element.
  always_comb begin
    res = '0;
    for (int i = 0; i < 8; i++) begin
      case (kind)
        K_SHLH:  res[16*i +: 16] = hw_shl(ra[16*i +: 16], use_imm ? imm[13:17] : rb[16*i+11 +: 5]);
        K_ROTH:  res[16*i +: 16] = hw_rot(ra[16*i +: 16], use_imm ? imm[14:17] : rb[16*i+12 +: 4]);
        default: ;
      endcase
    end
    for (int j = 0; j < 4; j++) begin
      case (kind)
        K_SHL:   res[32*j +: 32] = wd_shl(ra[32*j +: 32], use_imm ? imm[12:17] : rb[32*j+26 +: 6]);
        K_ROT:   res[32*j +: 32] = wd_rot(ra[32*j +: 32], use_imm ? imm[13:17] : rb[32*j+27 +: 5]);
        default: ;
      endcase
    end
  end

  // Next stage contents: flush kills valids, stall holds, otherwise advance one stage.
  always_comb begin
    rt_d   = rt_q;
    addr_d = addr_q;
    we_d   = we_q;
    if (flush) begin
      for (int k = 1; k <= LATENCY; k++) we_d[k] = 1'b0;
    end else if (!stall) begin
      rt_d[1]   = issue_vld ? res : '0;
      addr_d[1] = issue_vld ? rt_addr : 7'd0;
      we_d[1]   = issue_vld;
      for (int k = 2; k <= LATENCY; k++) begin
        rt_d[k]   = rt_q[k-1];
        addr_d[k] = addr_q[k-1];
        we_d[k]   = we_q[k-1];
      end
    end
  end

  // Stage registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 1; k <= LATENCY; k++) begin
        rt_q[k]   <= '0;
        addr_q[k] <= '0;
        we_q[k]   <= 1'b0;
      end
    end else begin
      rt_q   <= rt_d;
      addr_q <= addr_d;
      we_q   <= we_d;
    end
  end

  assign rt_wb        = rt_q[LATENCY];
  assign rt_addr_wb   = addr_q[LATENCY];
  assign reg_write_wb = we_q[LATENCY];

`ifdef SF2_HAZARD_QUERY_EN
  // Scan oldest to youngest so the youngest matching stage wins.
  always_comb begin
    q_hit   = 1'b0;
    q_stage = 4'd0;
    for (int k = LATENCY; k >= 1; k--) begin
      if (we_q[k] && (addr_q[k] == q_addr)) begin
        q_hit   = 1'b1;
        q_stage = 4'(k);
      end
    end
  end
`endif

endmodule

// File: tb/tb_simple_fixed2_pipe.sv
// Directed bench for simple_fixed2_pipe at LATENCY=3.
// Expected results are hand-computed per vector; a delay-line model tracks stall/flush/reset timing.
// Outputs are sampled on the falling edge, inputs driven on the falling edge.
module tb_simple_fixed2_pipe;

  localparam int LAT = 3;
  localparam logic [10:0] OP_SHLH  = 11'b00001011111;
  localparam logic [10:0] OP_SHLHI = 11'b00001111111;
  localparam logic [10:0] OP_SHL   = 11'b00001011011;
  localparam logic [10:0] OP_SHLI  = 11'b00001111011;
  localparam logic [10:0] OP_ROTH  = 11'b00001011100;
  localparam logic [10:0] OP_ROTHI = 11'b00001111100;
  localparam logic [10:0] OP_ROT   = 11'b00001011000;

  logic         clk = 1'b0;
  logic         reset, stall, flush, reg_write;
  logic [0:10]  op;
  logic [2:0]   fmt;
  logic [6:0]   rt_addr;
  logic [0:127] ra, rb;
  logic [0:17]  imm;
  logic [0:127] rt_wb;
  logic [6:0]   rt_addr_wb;
  logic         reg_write_wb;
`ifdef SF2_HAZARD_QUERY_EN
  logic [6:0]   q_addr;
  logic         q_hit;
  logic [3:0]   q_stage;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Delay-line model; index 0 = stage 1.
  logic [127:0] m_rt    [LAT];
  logic [6:0]   m_addr  [LAT];
  logic         m_we    [LAT];
  logic         m_known [LAT];
  logic [127:0] p_rt;
  logic [6:0]   p_addr;
  logic         p_we;

  always #5 clk = ~clk;

  simple_fixed2_pipe #(.LATENCY(LAT), .OPW(11)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .op           (op),
    .format       (fmt),
    .rt_addr      (rt_addr),
    .ra           (ra),
    .rb           (rb),
    .imm          (imm),
    .reg_write    (reg_write),
`ifdef SF2_HAZARD_QUERY_EN
    .q_addr       (q_addr),
    .q_hit        (q_hit),
    .q_stage      (q_stage),
`endif
    .rt_wb        (rt_wb),
    .rt_addr_wb   (rt_addr_wb),
    .reg_write_wb (reg_write_wb)
  );

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [10:0] o, input logic [2:0] f, input logic [6:0] a,
                       input logic [0:127] va, input logic [0:127] vb, input logic [0:17] im,
                       input logic [127:0] e_rt);
    op = o; fmt = f; rt_addr = a; ra = va; rb = vb; imm = im; reg_write = 1'b1;
    p_rt = e_rt; p_addr = a; p_we = 1'b1;
  endtask

  task automatic bubble();
    op = '0; fmt = 3'd0; rt_addr = 7'd9; ra = '1; rb = '0; imm = '0; reg_write = 1'b0;
    p_rt = '0; p_addr = '0; p_we = 1'b0;
  endtask

  task automatic step(input string tag);
    if (!reset) begin
      for (int k = 0; k < LAT; k++) begin
        m_rt[k] = '0; m_addr[k] = '0; m_we[k] = 1'b0; m_known[k] = 1'b1;
      end
    end else if (flush) begin
      for (int k = 0; k < LAT; k++) begin
        m_we[k] = 1'b0; m_known[k] = 1'b0;
      end
    end else if (!stall) begin
      for (int k = LAT-1; k > 0; k--) begin
        m_rt[k] = m_rt[k-1]; m_addr[k] = m_addr[k-1];
        m_we[k] = m_we[k-1]; m_known[k] = m_known[k-1];
      end
      m_rt[0] = p_rt; m_addr[0] = p_addr; m_we[0] = p_we; m_known[0] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, ".we"}, 128'(reg_write_wb), 128'(m_we[LAT-1]));
    if (m_known[LAT-1]) begin
      check_eq({tag, ".rt"}, rt_wb, m_rt[LAT-1]);
      check_eq({tag, ".addr"}, 128'(rt_addr_wb), 128'(m_addr[LAT-1]));
    end
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    bubble();
`ifdef SF2_HAZARD_QUERY_EN
    q_addr = 7'd3;
`endif
    @(negedge clk);
    step("rst0");
    step("rst1");
    reset = 1'b1;

    // Basic shlh by 1, then bubble
    drive(OP_SHLH, 3'd0, 7'd3, {8{16'h0001}}, {8{16'h0001}}, 18'd0, {8{16'h0002}});
    step("a0");
    bubble();
    step("a1");
    step("a2");
    step("a3");

    // Count boundaries and rotates, back to back
    drive(OP_SHLH, 3'd0, 7'd5, {8{16'hFFFF}}, {4{16'h0010, 16'h000F}}, 18'd0, {4{16'h0000, 16'h8000}});
    step("b0");
    drive(OP_SHLI, 3'd1, 7'd6, {4{32'h12345678}}, '0, 18'd32, 128'd0);
    step("b1");
    drive(OP_ROT, 3'd0, 7'd7, {4{32'h80000001}}, {4{32'd1}}, 18'd0, {4{32'h00000003}});
    step("b2");
    drive(OP_ROTHI, 3'd1, 7'd8, {8{16'h8001}}, '0, 18'd17, {8{16'h0003}});
    step("b3");
    drive(OP_ROTHI, 3'd2, 7'd9, {8{16'h8001}}, '0, 18'd1, 128'd0);
    p_addr = 7'd0; p_we = 1'b0;
    step("b4");
    bubble();
    step("b5");
    step("b6");

    // Stall mid-stream: outputs frozen, issue ignored, order preserved
    drive(OP_SHL, 3'd0, 7'd10, {4{32'h00000001}}, {4{32'd4}}, 18'd0, {4{32'h00000010}});
    step("s0");
    drive(OP_ROTH, 3'd0, 7'd11, {8{16'h1234}}, {8{16'd4}}, 18'd0, {8{16'h2341}});
    step("s1");
    drive(OP_SHLHI, 3'd1, 7'd12, {8{16'h0101}}, '0, 18'd3, {8{16'h0808}});
    step("s2");
    stall = 1'b1;
    drive(OP_SHL, 3'd0, 7'd13, {4{32'h00000001}}, {4{32'd1}}, 18'd0, {4{32'h00000002}});
    step("s3");
    step("s4");
    stall = 1'b0;
    bubble();
    step("s5");
    step("s6");
    step("s7");
    step("s8");

    // Flush with a new issue
    drive(OP_SHL, 3'd0, 7'd20, {4{32'h1}}, {4{32'd1}}, 18'd0, {4{32'h2}});
    step("f0");
    drive(OP_SHL, 3'd0, 7'd21, {4{32'h1}}, {4{32'd2}}, 18'd0, {4{32'h4}});
    step("f1");
    drive(OP_SHL, 3'd0, 7'd22, {4{32'h1}}, {4{32'd3}}, 18'd0, {4{32'h8}});
    flush = 1'b1;
    step("f2");
    flush = 1'b0;
    bubble();
    step("f3");
    step("f4");
    step("f5");

    // Flush and stall together: flush wins
    drive(OP_SHL, 3'd0, 7'd23, {4{32'h1}}, {4{32'd1}}, 18'd0, {4{32'h2}});
    step("g0");
    drive(OP_SHL, 3'd0, 7'd24, {4{32'h1}}, {4{32'd2}}, 18'd0, {4{32'h4}});
    step("g1");
    flush = 1'b1; stall = 1'b1;
    step("g2");
    flush = 1'b0; stall = 1'b0;
    bubble();
    step("g3");
    step("g4");
    step("g5");

    // Reset while two ops in flight
    drive(OP_SHL, 3'd0, 7'd25, {4{32'h1}}, {4{32'd1}}, 18'd0, {4{32'h2}});
    step("r0");
    drive(OP_SHL, 3'd0, 7'd26, {4{32'h1}}, {4{32'd2}}, 18'd0, {4{32'h4}});
    step("r1");
    reset = 1'b0;
    step("r2");
    reset = 1'b1;
    bubble();
    step("r3");

`ifdef SF2_HAZARD_QUERY_EN
    drive(OP_SHLH, 3'd0, 7'd3, {8{16'h0001}}, {8{16'h0001}}, 18'd0, {8{16'h0002}});
    step("h0");
    bubble();
    step("h1");
    check_eq("q_hit", 128'(q_hit), 128'd1);
    check_eq("q_stage", 128'(q_stage), 128'd2);
    flush = 1'b1;
    step("h2");
    flush = 1'b0;
    check_eq("q_hit_flush", 128'(q_hit), 128'd0);
    check_eq("q_stage_flush", 128'(q_stage), 128'd0);
`endif

    step("end0");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
